// File: rtl/as_pack.sv
// as_pack: shared GPIO slave constants and register address map
package as_pack;
  localparam int nr_gpios = 8;
  localparam int gpio_addr_width = 3;
  localparam logic [7:0] gpio_id_c = 8'h81;
  typedef enum logic [2:0] {
    GPIO_ID    = 3'd0,
    GPIO_DIR   = 3'd1,
    GPIO_OUT   = 3'd2,
    GPIO_IN    = 3'd3,
    GPIO_EDGE  = 3'd4,
    GPIO_IRQEN = 3'd5
  } gpio_reg_e;
endpackage

// File: rtl/as_gpio_sync.sv
// as_gpio_sync: per-pin 2-flop synchronizer plus delay flop with rising-edge output
module as_gpio_sync #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] rise_o
);
  logic [N-1:0] s1, s2, dly;
  logic [2:0] vld;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1  <= '0;
      s2  <= '0;
      dly <= '0;
      vld <= '0;
    end else begin
      s1  <= d_i;
      s2  <= s1;
      dly <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  assign q_o = s2;
  // edges count only once the delay flop holds real pad data, so pins high through reset stay quiet
  assign rise_o = vld[2] ? s2 & ~dly : '0;
endmodule

// File: rtl/as_gpio_slave.sv
// as_gpio_slave: bus-mapped GPIO block with direction, output, input, sticky edge and irq registers
module as_gpio_slave
  import as_pack::*;
#(
  parameter int NR_GPIO = nr_gpios,
  parameter int AW      = gpio_addr_width,
  parameter int DW      = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sel_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      wdata_i,
  output logic [DW-1:0]      rdata_o,
  output logic               ack_o,
  input  logic [NR_GPIO-1:0] gpio_i,
  output logic [NR_GPIO-1:0] gpio_o,
  output logic [NR_GPIO-1:0] gpio_oe_o,
  output logic               cs_o,
  output logic               irq_o
);
  localparam logic [AW-1:0] A_ID    = AW'(GPIO_ID);
  localparam logic [AW-1:0] A_DIR   = AW'(GPIO_DIR);
  localparam logic [AW-1:0] A_OUT   = AW'(GPIO_OUT);
  localparam logic [AW-1:0] A_IN    = AW'(GPIO_IN);
  localparam logic [AW-1:0] A_EDGE  = AW'(GPIO_EDGE);
  localparam logic [AW-1:0] A_IRQEN = AW'(GPIO_IRQEN);
  logic [NR_GPIO-1:0] dir_q, out_q, edge_q, irqen_q, in_q, rise, wd, clr;
  logic [DW-1:0] rd_mux;
  logic wr, rd;
  logic unused;
  assign unused = ^wdata_i[DW-1:NR_GPIO];
  assign wd = wdata_i[NR_GPIO-1:0];
  assign wr = sel_i & we_i;
  assign rd = sel_i & ~we_i;
  assign clr = (wr && addr_i == A_EDGE) ? wd : '0;
  assign gpio_o = out_q;
  assign gpio_oe_o = dir_q;
  as_gpio_sync #(.N(NR_GPIO)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (gpio_i),
    .q_o    (in_q),
    .rise_o (rise)
  );
  always_comb begin
    rd_mux = '0;
    case (addr_i)
      A_ID:    rd_mux = DW'(gpio_id_c);
      A_DIR:   rd_mux = DW'(dir_q);
      A_OUT:   rd_mux = DW'(out_q);
      A_IN:    rd_mux = DW'(in_q);
      A_EDGE:  rd_mux = DW'(edge_q);
      A_IRQEN: rd_mux = DW'(irqen_q);
      default: rd_mux = '0;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      dir_q   <= '0;
      out_q   <= '0;
      edge_q  <= '0;
      irqen_q <= '0;
      rdata_o <= '0;
      ack_o   <= 1'b0;
      cs_o    <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      ack_o   <= sel_i;
      rdata_o <= rd ? rd_mux : '0;
      cs_o    <= wr && addr_i == A_OUT;
      irq_o   <= |(edge_q & irqen_q);
      // a fresh rising edge overrides a same-cycle W1C clear
      edge_q  <= (edge_q & ~clr) | rise;
      if (wr && addr_i == A_DIR) dir_q <= wd;
      if (wr && addr_i == A_OUT) out_q <= wd;
      if (wr && addr_i == A_IRQEN) irqen_q <= wd;
    end
endmodule

// File: tb/tb_as_gpio_slave.sv
// tb_as_gpio_slave: directed and random bus/pad stimulus checked against a pad-history reference model
module tb_as_gpio_slave;
  import as_pack::*;
  localparam int N = nr_gpios;
  localparam int AW = gpio_addr_width;
  localparam int DW = 64;
  logic clk = 0, rst = 0, sel = 0, we = 0, ack, cs, irq;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [N-1:0] gpio_in = '0, gpio_out, gpio_oe;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  as_gpio_slave dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .gpio_i(gpio_in),
    .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .cs_o(cs), .irq_o(irq)
  );
  logic [N-1:0] m_dir, m_out, m_edge, m_ien;
  logic m_irq, m_ack, m_cs;
  logic [DW-1:0] m_rdata;
  logic [N-1:0] ph[$];
  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [N-1:0] m_in();
    int k = ph.size();
    return k >= 2 ? ph[k-2] : '0;
  endfunction
  function automatic logic [N-1:0] m_rise();
    int k = ph.size();
    return k >= 3 ? ph[k-2] & ~ph[k-3] : '0;
  endfunction
  function automatic logic [DW-1:0] reg_val(int a);
    case (a)
      0: return 64'h81;
      1: return DW'(m_dir);
      2: return DW'(m_out);
      3: return DW'(m_in());
      4: return DW'(m_edge);
      5: return DW'(m_ien);
      default: return '0;
    endcase
  endfunction
  task automatic m_reset();
    {m_dir, m_out, m_edge, m_ien} = '0;
    {m_irq, m_ack, m_cs} = '0;
    m_rdata = '0;
    ph.delete();
  endtask
  task automatic step();
    logic [N-1:0] wd;
    logic wr;
    int a;
    if (rst) begin
      m_reset();
      return;
    end
    wd = wdata[N-1:0];
    wr = sel & we;
    a = int'(addr);
    m_irq = |(m_edge & m_ien);
    m_ack = sel;
    m_cs = wr && a == 2;
    m_rdata = (sel && !we) ? reg_val(a) : '0;
    m_edge = (m_edge & ~((wr && a == 4) ? wd : '0)) | m_rise();
    if (wr && a == 1) m_dir = wd;
    if (wr && a == 2) m_out = wd;
    if (wr && a == 5) m_ien = wd;
    ph.push_back(gpio_in);
  endtask
  task automatic chk_outs();
    check("ack", ack, m_ack);
    check("rdata", rdata, m_rdata);
    check("cs", cs, m_cs);
    check("irq", irq, m_irq);
    check("gpio_o", gpio_out, m_out);
    check("gpio_oe", gpio_oe, m_dir);
  endtask
  task automatic tick();
    @(posedge clk);
    step();
    #1;
    chk_outs();
  endtask
  task automatic idle(int n);
    sel = 0;
    we = 0;
    repeat (n) tick();
  endtask
  task automatic xfer(logic w, int a, logic [DW-1:0] d);
    sel = 1;
    we = w;
    addr = AW'(a);
    wdata = d;
    tick();
    sel = 0;
    we = 0;
  endtask
  task automatic reset_pulse();
    rst = 1;
    #1;
    m_reset();
    chk_outs();
    tick();
    rst = 0;
  endtask
  initial begin
    #2;
    reset_pulse();
    xfer(0, 0, '0);
    check("id_read", rdata, 64'h81);
    check("id_ack", ack, 1);
    check("oe_after_reset", gpio_oe, 0);
    xfer(1, 1, 64'hFF);
    xfer(1, 2, 64'hA5);
    check("oe_ff", gpio_oe, 64'hFF);
    check("out_a5", gpio_out, 64'hA5);
    check("cs_pulse", cs, 1);
    idle(1);
    check("cs_drop", cs, 0);
    xfer(0, 2, '0);
    check("out_read", rdata, 64'hA5);
    xfer(1, 5, 64'h80);
    gpio_in[7] = 1'b1;
    idle(4);
    check("irq_set", irq, 1);
    xfer(0, 3, '0);
    check("in_read", rdata, 64'h80);
    xfer(0, 4, '0);
    check("edge_read", rdata, 64'h80);
    xfer(1, 4, 64'h80);
    check("irq_hold", irq, 1);
    idle(1);
    check("irq_clear", irq, 0);
    gpio_in[3] = 1'b1;
    for (int i = 0; i < 10 && m_rise() == '0; i++) idle(1);
    xfer(1, 4, 64'h08);
    xfer(0, 4, '0);
    check("edge_set_wins", rdata & 64'h08, 64'h08);
    xfer(0, 7, '0);
    check("unmapped_rd", rdata, 0);
    check("unmapped_rd_ack", ack, 1);
    xfer(1, 6, 64'hFF);
    check("unmapped_wr_ack", ack, 1);
    xfer(1, 0, 64'h00);
    check("id_wr_ack", ack, 1);
    xfer(0, 0, '0);
    check("id_kept", rdata, 64'h81);
    sel = 1;
    we = 1;
    addr = AW'(2);
    wdata = 64'h3C;
    rst = 1;
    #1;
    m_reset();
    chk_outs();
    tick();
    rst = 0;
    sel = 0;
    we = 0;
    tick();
    check("rst_no_ack", ack, 0);
    check("rst_no_cs", cs, 0);
    check("rst_out", gpio_out, 0);
    idle(5);
    xfer(0, 4, '0);
    check("no_edge_after_rst", rdata, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse();
      sel = $urandom_range(0, 9) < 7;
      we = 1'($urandom);
      addr = AW'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, N-1)] ^= 1'b1;
      tick();
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/as_gpio_slave.md
AS_GPIO_SLAVE -- requirements
Module: as_gpio_slave

Interface
REQ-001 Parameter NR_GPIO, default nr_gpios (as_pack), number of GPIO pins.
REQ-002 Parameter AW, default gpio_addr_width (as_pack), register word-address width, minimum 3.
REQ-003 Parameter DW, default 64, bus data width.
REQ-004 clk_i  in  1  system clock; one clock domain; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 sel_i  in  1  bus select; a transfer is requested in every cycle in which it is high.
REQ-007 we_i  in  1  1 = write, 0 = read; qualified by sel_i.
REQ-008 addr_i  in  AW  register word address.
REQ-009 wdata_i  in  DW  write data.
REQ-010 rdata_o  out  DW  read data; valid while ack_o is high.
REQ-011 ack_o  out  1  transfer acknowledge, high for one cycle per transfer.
REQ-012 gpio_i  in  NR_GPIO  pad input values (asynchronous).
REQ-013 gpio_o  out  NR_GPIO  pad output values.
REQ-014 gpio_oe_o  out  NR_GPIO  per-pin output enable; the top level builds the tristate.
REQ-015 cs_o  out  1  one-cycle strobe that marks an OUT register update.
REQ-016 irq_o  out  1  level interrupt.

Function
REQ-017 Register map (word addresses): 0 ID (RO), 1 DIR (RW), 2 OUT (RW), 3 IN (RO), 4 EDGE (RW1C), 5 IRQEN (RW). Addresses 6 and above are unmapped.
REQ-018 ID register reads as the constant gpio_id_c (0x81), zero-extended to DW.
REQ-019 Bits wider than NR_GPIO read as 0 and are ignored on write.
REQ-020 Write: the register updates at the clock edge where sel_i and we_i are both high. ack_o goes high in the following cycle.
REQ-021 Read: rdata_o is registered from the address sampled at the sel_i edge. ack_o and rdata_o are valid one cycle later, giving a read latency of 1.
REQ-022 Back-to-back transfers (sel_i held high) SHALL each be accepted and acked, one per cycle.
REQ-023 Unmapped read returns 0 and is acked. Unmapped write and writes to ID or IN have no effect and are acked.
REQ-024 Outside an ack cycle, rdata_o SHALL be 0.
REQ-025 gpio_o equals OUT. gpio_oe_o equals DIR.
REQ-026 gpio_i passes through a 2-flop synchronizer per bit. The IN register is the second flop, so there are 2 cycles of latency from a stable pad value to the IN register.
REQ-027 A rising edge is a 0->1 transition between the IN register and a third delay flop. The rising edge sets the corresponding EDGE bit, and the bit stays set (sticky).
REQ-028 Writing 1 to an EDGE bit clears that bit. Writing 0 leaves it unchanged.
REQ-029 If a rising edge and a W1C clear hit the same EDGE bit in the same cycle, the set wins.
REQ-030 irq_o is registered as the OR of (EDGE AND IRQEN). It asserts 1 cycle after either an EDGE set or an IRQEN write.
REQ-031 cs_o pulses high for exactly one cycle, in the cycle after any accepted write to OUT, including writes that leave OUT unchanged.
REQ-032 Edge detection runs regardless of the DIR setting.

Reset
REQ-033 While rst_i is high, the following are 0: DIR, OUT, EDGE, IRQEN, the synchronizer and delay flops, rdata_o, ack_o, cs_o and irq_o. All pads are therefore inputs.
REQ-034 Reset asserted mid-transfer cancels the pending ack. No ack is issued after reset release for a transfer requested before reset.
REQ-035 After reset release, the first rising edge is detected only once the delay flop holds 0, so pins held at 1 through reset raise no edge.

Structure
REQ-036 The following live in as_pack: nr_gpios, gpio_addr_width, gpio_id_c, and an enum of register addresses (GPIO_ID, GPIO_DIR, GPIO_OUT, GPIO_IN, GPIO_EDGE, GPIO_IRQEN).
REQ-037 One sub-module, as_gpio_sync: an NR_GPIO-wide 2-flop synchronizer plus delay flop, with rise output. Everything else stays in as_gpio_slave.

Verification
REQ-038 After reset, read addr 0 -> ack_o exactly 1 cycle after sel_i, rdata_o = 0x81, and gpio_oe_o = 0.
REQ-039 Write DIR = 0xFF, then OUT = 0xA5 -> gpio_oe_o = 0xFF and gpio_o = 0xA5 from the cycle after the OUT write. cs_o is high for exactly 1 cycle. Reading OUT returns 0xA5.
REQ-040 Drive gpio_i[7] 0->1, with IRQEN = 0x80 -> IN[7] = 1 after 2 cycles, EDGE = 0x80, irq_o = 1. A W1C write of 0x80 clears EDGE and irq_o falls 1 cycle later.
REQ-041 Rising edge on gpio_i[3] timed so it sets EDGE[3] in the same cycle as a W1C write of 0x08 -> EDGE[3] remains 1.
REQ-042 Read addr 7, write addr 6, and write ID = 0x00 -> all three are acked, the read returns 0, and a following ID read still returns 0x81.
REQ-043 Assert rst_i on the sel_i cycle of an OUT write of 0x3C -> no ack, OUT = 0, cs_o stays 0, and all outputs are 0 after release.
